// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus target; each accepted start runs one read/write
// on an internal word RAM after WAIT_CYCLES wait states, with busy held throughout.
module cpu_bus_responder #(
   parameter int ADDR_W      = 27,
   parameter int DATA_W      = 32,
   parameter int RAM_AW      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              we,
   input  logic              start,
   output logic [DATA_W-1:0] q,
   output logic              busy,
   output logic              oor
);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, q_q, q_d;
   logic we_q, we_d, oor_q, oor_d;
   logic op, in_range;
   logic [DATA_W-1:0] ram [2**RAM_AW];
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = we_q;
      q_d      = q_q;
      oor_d    = 1'b0;
      in_range = addr_q[ADDR_W-1:RAM_AW] == '0;
      op       = (state_q == ACCESS) && (cnt_q == '0);
      busy     = (state_q == ACCESS) || ((state_q == IDLE) && start);
      if (state_q == IDLE && start) begin
         state_d = ACCESS;
         cnt_d   = CNT_W'(WAIT_CYCLES);
         addr_d  = address;
         data_d  = data;
         we_d    = we;
      end else if (state_q == ACCESS) begin
         if (!op) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            state_d = IDLE;
            oor_d   = !in_range;
            // out-of-range reads return zero; writes never touch q
            if (!we_q) q_d = in_range ? ram[addr_q[RAM_AW-1:0]] : '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         q_q     <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         q_q     <= q_d;
         oor_q   <= oor_d;
      end
   end
   // RAM survives reset; a reset edge suppresses a pending write
   always_ff @(posedge clk) begin
      if (reset && op && we_q && in_range) ram[addr_q[RAM_AW-1:0]] <= data_q;
   end
   assign q   = q_q;
   assign oor = oor_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: table-driven request vectors on a WAIT_CYCLES=2 instance
// plus hand sequences for ignored start, reset abort and a WAIT_CYCLES=0 instance.
module tb_cpu_bus_responder;
   logic clk = 1'b0, reset = 1'b0;
   logic [26:0] address = '0, a0 = '0;
   logic [31:0] data = '0, d0 = '0, q, q0;
   logic we = 1'b0, start = 1'b0, busy, oor;
   logic we0 = 1'b0, st0 = 1'b0, busy0, oor0;
   int tests = 0, failed = 0;

   always #5 clk = ~clk;

   cpu_bus_responder #(.ADDR_W(27), .DATA_W(32), .RAM_AW(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .address(address), .data(data), .we(we),
      .start(start), .q(q), .busy(busy), .oor(oor));

   cpu_bus_responder #(.ADDR_W(27), .DATA_W(32), .RAM_AW(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .address(a0), .data(d0), .we(we0),
      .start(st0), .q(q0), .busy(busy0), .oor(oor0));

   typedef struct {
      logic        we;
      logic [26:0] addr;
      logic [31:0] data;
      logic [31:0] exp_q;
      logic        exp_oor;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issues one request, returns busy length, oor seen in the first idle cycle,
   // and whether oor was ever high before that cycle.
   task automatic req(input logic w, input logic [26:0] a, input logic [31:0] d,
                      output int blen, output logic oor_end, output logic oor_early);
      @(negedge clk);
      address = a; data = d; we = w; start = 1'b1;
      #1;
      blen = busy ? 1 : 0;
      oor_early = oor;
      @(negedge clk);
      start = 1'b0; address = ~a; data = ~d; we = ~w;
      while (busy && blen < 20) begin
         blen++;
         oor_early |= oor;
         @(negedge clk);
      end
      oor_end = oor;
   endtask

   initial begin
      int blen;
      logic oe, oea;
      vecs[0]  = '{1'b1, 27'h0,       32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 27'h5,       32'hDEADBEEF, 32'h0,        1'b0};
      vecs[2]  = '{1'b0, 27'h5,       32'h0,        32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b1, 27'h7,       32'h00000077, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b1, 27'h9,       32'h00000099, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{1'b0, 27'h400,     32'h0,        32'h0,        1'b1};
      vecs[6]  = '{1'b1, 27'h400,     32'h00001234, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 27'h0,       32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[8]  = '{1'b0, 27'h7,       32'h0,        32'h00000077, 1'b0};
      vecs[9]  = '{1'b0, 27'h4000005, 32'h0,        32'h0,        1'b1};
      vecs[10] = '{1'b0, 27'h5,       32'h0,        32'hDEADBEEF, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_q", q, 32'h0);
      chk("rst_oor", {31'b0, oor}, 32'h0);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_outs", {q[29:0], busy, oor}, 32'h0);
      end

      for (int i = 0; i < 11; i++) begin
         req(vecs[i].we, vecs[i].addr, vecs[i].data, blen, oe, oea);
         chk($sformatf("v%0d_busy_len", i), 32'(blen), 32'd4);
         chk($sformatf("v%0d_q", i), q, vecs[i].exp_q);
         chk($sformatf("v%0d_oor", i), {31'b0, oe}, {31'b0, vecs[i].exp_oor});
         chk($sformatf("v%0d_oor_early", i), {31'b0, oea}, 32'h0);
      end

      @(negedge clk);
      address = 27'h5; we = 1'b0; start = 1'b1;
      @(negedge clk);
      address = 27'h7; data = 32'h55; we = 1'b1; start = 1'b1;
      blen = 2;
      @(negedge clk);
      start = 1'b0;
      while (busy && blen < 20) begin
         blen++;
         @(negedge clk);
      end
      chk("ign_busy_len", 32'(blen), 32'd4);
      chk("ign_q", q, 32'hDEADBEEF);
      req(1'b0, 27'h7, 32'h0, blen, oe, oea);
      chk("ign_ram7", q, 32'h00000077);

      @(negedge clk);
      address = 27'h9; data = 32'h00000BAD; we = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_q", q, 32'h0);
      req(1'b0, 27'h9, 32'h0, blen, oe, oea);
      chk("abort_ram9", q, 32'h00000099);

      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         a0 = 27'(i); d0 = 32'(i * 17); we0 = 1'b1; st0 = 1'b1;
         @(negedge clk);
         st0 = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      we0 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         a0 = 27'(i); st0 = 1'b1;
         #1;
         chk($sformatf("b2b%0d_busy_start", i), {31'b0, busy0}, 32'h1);
         @(negedge clk);
         st0 = 1'b0; a0 = '1;
         chk($sformatf("b2b%0d_busy_acc", i), {31'b0, busy0}, 32'h1);
         @(negedge clk);
         chk($sformatf("b2b%0d_busy_low", i), {31'b0, busy0}, 32'h0);
         chk($sformatf("b2b%0d_q", i), q0, 32'(i * 17));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
